// File: rtl/ps2_kb_cmd_sequencer_if.sv
// PS/2 link seen by the command sequencer: transmitter load/busy, receiver strobe and
// the key-event forward toward the core.
interface ps2_kb_cmd_sequencer_if;
    // Handshake: tx_load is a one-cycle strobe with tx_data valid in that same cycle; the
    // transmitter raises tx_busy within two cycles and drops it when the byte is out, with
    // tx_error meaningful once tx_busy is low. rx_interrupt is a one-cycle strobe that
    // qualifies rx_scancode; key_interrupt is a one-cycle strobe that qualifies the same byte.
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_busy;
    logic       tx_error;
    logic       rx_enable;
    logic       rx_interrupt;
    logic [7:0] rx_scancode;
    logic       key_interrupt;

    modport master (
        output tx_data, tx_load, rx_enable, key_interrupt,
        input  tx_busy, tx_error, rx_interrupt, rx_scancode
    );

    modport slave (
        input  tx_data, tx_load, rx_enable, key_interrupt,
        output tx_busy, tx_error, rx_interrupt, rx_scancode
    );
endinterface

// File: rtl/ps2_kb_cmd_sequencer.sv
// Arbitrates keyboard reset, LED update and raw command requests onto the single PS/2
// transmitter, runs each byte sequence to completion and gates the receiver meanwhile.
module ps2_kb_cmd_sequencer #(
    parameter logic [23:0] ACK_TIMEOUT = 24'd2_000_000,
    parameter logic [23:0] BAT_TIMEOUT = 24'd12_000_000,
    parameter logic [3:0]  MAX_RETRIES = 4'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbreset_req,
    input  logic       led_update,
    input  logic [2:0] led_state,
    input  logic       cmd_load,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [2:0] dbg_state,
    ps2_kb_cmd_sequencer_if.master link
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TXWAIT, S_RESP, S_BAT} state_t;
    typedef enum logic [1:0] {K_RST, K_CMD, K_LED} kind_t;

    state_t      state, state_d;
    kind_t       kind, kind_d;
    logic        byte_idx, idx_d;
    logic [3:0]  retry_cnt, retry_d;
    logic [23:0] timer;
    logic        pend_rst, pend_cmd, pend_led;
    logic        clr_rst, clr_cmd, clr_led;
    logic [7:0]  cmd_reg, cur_cmd, cur_cmd_d;
    logic [2:0]  led_reg, cur_led, cur_led_d;
    logic        done_d, fail_d, fwd, do_retry, rx_en_d;
    logic [7:0]  tx_byte;

    assign dbg_state = state;

    always_comb begin
        state_d   = state;
        kind_d    = kind;
        idx_d     = byte_idx;
        retry_d   = retry_cnt;
        cur_cmd_d = cur_cmd;
        cur_led_d = cur_led;
        clr_rst   = 1'b0;
        clr_cmd   = 1'b0;
        clr_led   = 1'b0;
        done_d    = 1'b0;
        fail_d    = 1'b0;
        fwd       = 1'b0;
        do_retry  = 1'b0;
        case (state)
            S_IDLE: begin
                fwd     = link.rx_interrupt;
                idx_d   = 1'b0;
                retry_d = '0;
                if (pend_rst) begin
                    state_d = S_LOAD; kind_d = K_RST; clr_rst = 1'b1;
                end else if (pend_cmd) begin
                    state_d = S_LOAD; kind_d = K_CMD; clr_cmd = 1'b1; cur_cmd_d = cmd_reg;
                end else if (pend_led) begin
                    state_d = S_LOAD; kind_d = K_LED; clr_led = 1'b1; cur_led_d = led_reg;
                end
            end
            S_LOAD: state_d = S_TXWAIT;
            S_TXWAIT: begin
                // The transmitter needs a couple of cycles to raise tx_busy after the load.
                if (timer >= 24'd2 && !link.tx_busy) begin
                    if (link.tx_error) do_retry = 1'b1;
                    else               state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (link.rx_interrupt) begin
                    if (link.rx_scancode == 8'hFA) begin
                        retry_d = '0;
                        if (kind == K_LED && !byte_idx) begin
                            idx_d = 1'b1; state_d = S_LOAD;
                        end else if (kind == K_RST) begin
                            state_d = S_BAT;
                        end else begin
                            done_d = 1'b1; state_d = S_IDLE;
                        end
                    end else if (link.rx_scancode == 8'hFE) begin
                        do_retry = 1'b1;
                    end else begin
                        fwd = 1'b1;
                    end
                end else if (timer >= ACK_TIMEOUT) begin
                    do_retry = 1'b1;
                end
            end
            S_BAT: begin
                if (link.rx_interrupt) begin
                    if (link.rx_scancode == 8'hAA) begin
                        done_d = 1'b1; state_d = S_IDLE;
                    end else if (link.rx_scancode == 8'hFC) begin
                        fail_d = 1'b1; state_d = S_IDLE;
                    end else begin
                        fwd = 1'b1;
                    end
                end else if (timer >= BAT_TIMEOUT) begin
                    fail_d = 1'b1; state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_retry) begin
            if (retry_cnt == MAX_RETRIES) begin
                fail_d = 1'b1; state_d = S_IDLE;
            end else begin
                retry_d = retry_cnt + 4'd1; state_d = S_LOAD;
            end
        end
    end

    // A byte arriving while the receiver is about to be gated is dropped, not forwarded.
    assign rx_en_d = !(state_d == S_LOAD || state_d == S_TXWAIT);

    always_comb begin
        case (kind_d)
            K_RST:   tx_byte = 8'hFF;
            K_CMD:   tx_byte = cur_cmd_d;
            default: tx_byte = idx_d ? {5'b0, cur_led_d} : 8'hED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            kind               <= K_RST;
            byte_idx           <= 1'b0;
            retry_cnt          <= '0;
            timer              <= '0;
            pend_rst           <= 1'b0;
            pend_cmd           <= 1'b0;
            pend_led           <= 1'b0;
            cmd_reg            <= '0;
            led_reg            <= '0;
            cur_cmd            <= '0;
            cur_led            <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            fail               <= 1'b0;
            link.tx_load       <= 1'b0;
            link.tx_data       <= '0;
            link.rx_enable     <= 1'b1;
            link.key_interrupt <= 1'b0;
        end else begin
            state     <= state_d;
            kind      <= kind_d;
            byte_idx  <= idx_d;
            retry_cnt <= retry_d;
            cur_cmd   <= cur_cmd_d;
            cur_led   <= cur_led_d;
            timer     <= (state_d != state) ? '0 : ((&timer) ? timer : timer + 24'd1);
            // A new request beats the clear, so a pulse during arbitration queues another run.
            pend_rst  <= (pend_rst & ~clr_rst) | kbreset_req;
            pend_cmd  <= (pend_cmd & ~clr_cmd) | cmd_load;
            pend_led  <= (pend_led & ~clr_led) | led_update;
            if (cmd_load)   cmd_reg <= cmd_data;
            if (led_update) led_reg <= led_state;
            busy               <= (state_d != S_IDLE);
            done               <= done_d;
            fail               <= fail_d;
            link.tx_load       <= (state_d == S_LOAD);
            if (state_d == S_LOAD) link.tx_data <= tx_byte;
            link.rx_enable     <= rx_en_d;
            link.key_interrupt <= fwd & rx_en_d;
        end
    end
endmodule

// File: tb/tb_ps2_kb_cmd_sequencer.sv
// Directed bench for the PS/2 command sequencer with a transmitter/keyboard model.
`timescale 1ns/1ps
module tb_ps2_kb_cmd_sequencer;
    localparam logic [23:0] ACK_TO = 24'd60;
    localparam logic [23:0] BAT_TO = 24'd300;
    localparam int TX_CYC = 5;
    localparam int GAP    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       kbreset_req, led_update, cmd_load;
    logic [2:0] led_state;
    logic [7:0] cmd_data;
    logic       busy, done, fail;
    logic [2:0] dbg_state;

    ps2_kb_cmd_sequencer_if link();

    ps2_kb_cmd_sequencer #(
        .ACK_TIMEOUT(ACK_TO), .BAT_TIMEOUT(BAT_TO), .MAX_RETRIES(4'd2)
    ) dut (
        .clk(clk), .rst(rst), .kbreset_req(kbreset_req), .led_update(led_update),
        .led_state(led_state), .cmd_load(cmd_load), .cmd_data(cmd_data),
        .busy(busy), .done(done), .fail(fail), .dbg_state(dbg_state), .link(link)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    // ---------------- transmitter + keyboard model ----------------
    // resp entry per accepted transmit: [15:8] first reply byte, [7:0] second, 0 = none
    logic [15:0] resp_q[$];
    logic [7:0]  byte_q[$];
    logic [15:0] mdl_r;
    int          busy_cnt = 0;
    int          gap_cnt  = 0;
    int          err_left = 0;
    int          rx_cyc_q[$];

    always @(negedge clk) begin
        link.rx_interrupt = 1'b0;
        if (rst) begin
            busy_cnt = 0;
            byte_q.delete();
            link.tx_busy     = 1'b0;
            link.tx_error    = 1'b0;
            link.rx_scancode = 8'h00;
        end else if (link.tx_load) begin
            busy_cnt = TX_CYC;
            link.tx_busy  = 1'b1;
            link.tx_error = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                link.tx_busy = 1'b0;
                if (err_left > 0) begin
                    err_left--;
                    link.tx_error = 1'b1;
                end else if (resp_q.size() > 0) begin
                    mdl_r = resp_q.pop_front();
                    if (mdl_r[15:8] != 8'h00) byte_q.push_back(mdl_r[15:8]);
                    if (mdl_r[7:0] != 8'h00)  byte_q.push_back(mdl_r[7:0]);
                    gap_cnt = GAP;
                end
            end
        end else if (byte_q.size() > 0) begin
            if (gap_cnt > 0) gap_cnt--;
            else begin
                link.rx_scancode  = byte_q.pop_front();
                link.rx_interrupt = 1'b1;
                rx_cyc_q.push_back(cyc);
                gap_cnt = GAP;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int ld_cyc_q[$];
    int key_cyc_q[$];
    int n_done = 0, n_fail_p = 0, n_key = 0, n_viol = 0;
    int done_cyc = 0, fail_cyc = 0;
    logic busy_at_end = 1'b0;

    always @(negedge clk) begin
        if (link.tx_load) begin
            got_q.push_back(link.tx_data);
            ld_cyc_q.push_back(cyc);
        end
        if (done) begin n_done++;   done_cyc = cyc; busy_at_end = busy; end
        if (fail) begin n_fail_p++; fail_cyc = cyc; busy_at_end = busy; end
        if (link.key_interrupt) begin n_key++; key_cyc_q.push_back(cyc); end
        if (link.key_interrupt && !link.rx_enable) n_viol++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic clear_sb();
        exp_q.delete(); got_q.delete(); ld_cyc_q.delete(); key_cyc_q.delete();
        rx_cyc_q.delete(); resp_q.delete();
        n_done = 0; n_fail_p = 0; n_key = 0; n_viol = 0; err_left = 0;
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_end(input int total, input string tag);
        int k;
        k = 0;
        while (n_done + n_fail_p < total && k < 20000) begin
            @(posedge clk);
            k++;
        end
        #2;
        check({tag, " end_seen"}, 32'(n_done + n_fail_p >= total), 32'd1);
        repeat (30) tick();
    endtask

    task automatic check_tx(input string tag);
        check({tag, " tx_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, " tx_byte"}, got_q.pop_front(), exp_q.pop_front());
        check({tag, " key_gated"}, n_viol, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic            rq_rst, rq_cmd, rq_led;
        logic [7:0]      cmd;
        logic [2:0]      led;
        logic [3:0]      n_err, n_resp;
        logic [7:0][15:0] resp;
        logic [3:0]      n_tx;
        logic [7:0][7:0] tx;
        logic [3:0]      n_done, n_fail, n_key;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int i);
        vec_t  v;
        string tag;
        v   = vecs[i];
        tag = $sformatf("vec%0d", i);
        clear_sb();
        for (int j = 0; j < int'(v.n_resp); j++) resp_q.push_back(v.resp[j]);
        for (int j = 0; j < int'(v.n_tx); j++)   exp_q.push_back(v.tx[j]);
        err_left = int'(v.n_err);
        tick();
        kbreset_req = v.rq_rst; cmd_load = v.rq_cmd; led_update = v.rq_led;
        cmd_data = v.cmd; led_state = v.led;
        tick();
        kbreset_req = 1'b0; cmd_load = 1'b0; led_update = 1'b0;
        wait_end(int'(v.n_done) + int'(v.n_fail), tag);
        check_tx(tag);
        check({tag, " done_count"}, n_done, v.n_done);
        check({tag, " fail_count"}, n_fail_p, v.n_fail);
        check({tag, " key_count"}, n_key, v.n_key);
    endtask

    task automatic pulse_cmd(input logic [7:0] b);
        cmd_load = 1'b1; cmd_data = b;
        tick();
        cmd_load = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) vecs[i] = '0;
        // LED 101: ED, FA, 05, FA
        vecs[0].rq_led = 1; vecs[0].led = 3'b101; vecs[0].n_resp = 2;
        vecs[0].resp[0] = 16'hFA00; vecs[0].resp[1] = 16'hFA00;
        vecs[0].n_tx = 2; vecs[0].tx[0] = 8'hED; vecs[0].tx[1] = 8'h05; vecs[0].n_done = 1;
        // all three at once: rst > cmd > led
        vecs[1].rq_rst = 1; vecs[1].rq_cmd = 1; vecs[1].rq_led = 1;
        vecs[1].cmd = 8'hF4; vecs[1].led = 3'b101; vecs[1].n_resp = 4;
        vecs[1].resp[0] = 16'hFAAA; vecs[1].resp[1] = 16'hFA00;
        vecs[1].resp[2] = 16'hFA00; vecs[1].resp[3] = 16'hFA00;
        vecs[1].n_tx = 4; vecs[1].tx[0] = 8'hFF; vecs[1].tx[1] = 8'hF4;
        vecs[1].tx[2] = 8'hED; vecs[1].tx[3] = 8'h05; vecs[1].n_done = 3;
        // two resends then ack
        vecs[2].rq_cmd = 1; vecs[2].cmd = 8'hF4; vecs[2].n_resp = 3;
        vecs[2].resp[0] = 16'hFE00; vecs[2].resp[1] = 16'hFE00; vecs[2].resp[2] = 16'hFA00;
        vecs[2].n_tx = 3; vecs[2].tx[0] = 8'hF4; vecs[2].tx[1] = 8'hF4; vecs[2].tx[2] = 8'hF4;
        vecs[2].n_done = 1;
        // three resends: retries exhausted
        vecs[3] = vecs[2]; vecs[3].resp[2] = 16'hFE00; vecs[3].n_done = 0; vecs[3].n_fail = 1;
        // non-response byte in RESP is forwarded, ack is not
        vecs[4].rq_cmd = 1; vecs[4].cmd = 8'hF4; vecs[4].n_resp = 1; vecs[4].resp[0] = 16'h1CFA;
        vecs[4].n_tx = 1; vecs[4].tx[0] = 8'hF4; vecs[4].n_done = 1; vecs[4].n_key = 1;
        // transmitter error counts as a retry
        vecs[5].rq_cmd = 1; vecs[5].cmd = 8'hF3; vecs[5].n_err = 1; vecs[5].n_resp = 1;
        vecs[5].resp[0] = 16'hFA00; vecs[5].n_tx = 2; vecs[5].tx[0] = 8'hF3; vecs[5].tx[1] = 8'hF3;
        vecs[5].n_done = 1;
        // reset acked, then BAT failure code
        vecs[6].rq_rst = 1; vecs[6].n_resp = 1; vecs[6].resp[0] = 16'hFAFC;
        vecs[6].n_tx = 1; vecs[6].tx[0] = 8'hFF; vecs[6].n_fail = 1;
        // silent keyboard: three transmits then fail
        vecs[7].rq_cmd = 1; vecs[7].cmd = 8'hF2;
        vecs[7].n_tx = 3; vecs[7].tx[0] = 8'hF2; vecs[7].tx[1] = 8'hF2; vecs[7].tx[2] = 8'hF2;
        vecs[7].n_fail = 1;

        // ---- clock/reset ----
        rst = 1'b1; kbreset_req = 1'b0; led_update = 1'b0; cmd_load = 1'b0;
        led_state = 3'b000; cmd_data = 8'h00;
        repeat (3) tick();
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst fail", fail, 1'b0);
        check("rst tx_load", link.tx_load, 1'b0);
        check("rst tx_data", link.tx_data, 8'h00);
        check("rst key_interrupt", link.key_interrupt, 1'b0);
        check("rst rx_enable", link.rx_enable, 1'b1);
        rst = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 8; i++) run_vec(i);

        // ---- request latency, rx gating, done timing ----
        clear_sb(); resp_q.push_back(16'hFA00); exp_q.push_back(8'hF4);
        pulse_cmd(8'hF4);
        check("lat n+1 busy", busy, 1'b0);
        check("lat n+1 tx_load", link.tx_load, 1'b0);
        tick();
        check("lat n+2 busy", busy, 1'b1);
        check("lat n+2 tx_load", link.tx_load, 1'b1);
        check("lat n+2 tx_data", link.tx_data, 8'hF4);
        tick();
        check("txwait tx_load", link.tx_load, 1'b0);
        check("txwait rx_enable", link.rx_enable, 1'b0);
        wait_end(1, "lat");
        check_tx("lat");
        check("lat done_cycle", done_cyc, (rx_cyc_q.size() > 0) ? rx_cyc_q[$] + 1 : -1);
        check("lat busy_at_done", busy_at_end, 1'b0);
        check("lat rx_enable_idle", link.rx_enable, 1'b1);

        // ---- request during arbitration queues a rerun; value snapshot at entry ----
        clear_sb(); resp_q.push_back(16'hFA00); resp_q.push_back(16'hFA00);
        exp_q.push_back(8'hF4); exp_q.push_back(8'hF5);
        cmd_load = 1'b1; cmd_data = 8'hF4;
        tick();
        cmd_data = 8'hF5;
        tick();
        cmd_load = 1'b0;
        wait_end(2, "arb");
        check_tx("arb");
        check("arb done_count", n_done, 2);

        // ---- key_interrupt one cycle after rx_interrupt ----
        clear_sb(); resp_q.push_back(16'h1CFA); exp_q.push_back(8'hF4);
        pulse_cmd(8'hF4);
        wait_end(1, "fwd");
        check_tx("fwd");
        check("fwd key_count", n_key, 1);
        check("fwd key_cycle", (key_cyc_q.size() > 0) ? key_cyc_q[0] : -1,
              (rx_cyc_q.size() > 0) ? rx_cyc_q[0] + 1 : -2);

        // ---- ack timeout spacing: load L, busy drops in L+5, RESP from L+6, reload L+7+A ----
        clear_sb();
        pulse_cmd(8'hF2);
        wait_end(1, "tmo");
        check("tmo loads", ld_cyc_q.size(), 3);
        check("tmo gap", (ld_cyc_q.size() > 1) ? ld_cyc_q[1] - ld_cyc_q[0] : -1, int'(ACK_TO) + 7);
        check("tmo fail_cycle", fail_cyc, (ld_cyc_q.size() > 2) ? ld_cyc_q[2] + int'(ACK_TO) + 7 : -1);
        check("tmo fail_count", n_fail_p, 1);
        check("tmo busy_at_fail", busy_at_end, 1'b0);

        // ---- reset in the middle of an LED sequence ----
        clear_sb();
        led_update = 1'b1; led_state = 3'b011;
        tick();
        led_update = 1'b0;
        for (int k = 0; k < 20 && got_q.size() == 0; k++) tick();
        tick(); tick();
        check("mid busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid busy", busy, 1'b0);
        check("mid tx_load", link.tx_load, 1'b0);
        check("mid tx_data", link.tx_data, 8'h00);
        check("mid rx_enable", link.rx_enable, 1'b1);
        repeat (3) tick();
        check("mid done", done, 1'b0);
        check("mid fail", fail, 1'b0);
        check("mid key_interrupt", link.key_interrupt, 1'b0);
        rst = 1'b0;
        repeat (20) tick();
        check("mid no_relaunch", got_q.size(), 1);
        check("mid no_done", n_done, 0);
        check("mid no_fail", n_fail_p, 0);
        clear_sb(); resp_q.push_back(16'hFA00); exp_q.push_back(8'hF4);
        pulse_cmd(8'hF4);
        wait_end(1, "post");
        check_tx("post");
        check("post done_count", n_done, 1);
        check("post fail_count", n_fail_p, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
